// File: rtl/x_val_joiner.sv
// x_val_joiner: buffers the x value stream and the matrix nonzero stream in two
// independent circular FIFOs and emits one registered (val, x, row_end) triple
// per cycle whenever both FIFOs hold an entry and downstream is not stalled.
module x_val_joiner #(
  parameter int DEPTH      = 16,
  parameter int LOG2_DEPTH = 4,
  parameter int AF_MARGIN  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_x,
  input  logic [63:0] x_val,
  output logic        x_stall,
  input  logic        push_val,
  input  logic [63:0] val,
  input  logic        row_end,
  output logic        val_almost_full,
  output logic        out_push,
  output logic [63:0] out_val,
  output logic [63:0] out_x,
  output logic        out_row_end,
  input  logic        out_stall,
  output logic        overflow,
  output logic [31:0] pair_count
);

  localparam int CW = LOG2_DEPTH + 1;

  // x FIFO storage and bookkeeping
  logic [63:0]           x_mem [DEPTH];
  logic [LOG2_DEPTH-1:0] x_wp, x_rp;
  logic [CW-1:0]         x_cnt, x_cnt_nxt;
  logic                  x_full, x_empty, x_wr, x_rd, x_drop;

  // val FIFO storage: row_end travels with its value in bit 64
  logic [64:0]           v_mem [DEPTH];
  logic [LOG2_DEPTH-1:0] v_wp, v_rp;
  logic [CW-1:0]         v_cnt, v_cnt_nxt;
  logic                  v_full, v_empty, v_wr, v_rd, v_drop;

  logic                  join_go;

  // Flags, join decision, push acceptance and next occupancy for both FIFOs
  always_comb begin
    x_full    = (x_cnt == CW'(DEPTH));
    x_empty   = (x_cnt == '0);
    v_full    = (v_cnt == CW'(DEPTH));
    v_empty   = (v_cnt == '0);
    join_go   = !x_empty && !v_empty && !out_stall;
    x_rd      = join_go;
    v_rd      = join_go;
    // A push on a full FIFO is still accepted when that FIFO pops in the same cycle
    x_wr      = push_x   && (!x_full || x_rd);
    v_wr      = push_val && (!v_full || v_rd);
    x_drop    = push_x   && !x_wr;
    v_drop    = push_val && !v_wr;
    x_cnt_nxt = x_cnt + CW'(x_wr) - CW'(x_rd);
    v_cnt_nxt = v_cnt + CW'(v_wr) - CW'(v_rd);
  end

  // FIFO RAM writes (storage needs no reset; pointers and counts gate visibility)
  always_ff @(posedge clk) begin
    if (x_wr) x_mem[x_wp] <= x_val;
    if (v_wr) v_mem[v_wp] <= {row_end, val};
  end

  // Pointers, occupancy counts, almost-full flags and sticky overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_wp            <= '0;
      x_rp            <= '0;
      x_cnt           <= '0;
      v_wp            <= '0;
      v_rp            <= '0;
      v_cnt           <= '0;
      x_stall         <= 1'b0;
      val_almost_full <= 1'b0;
      overflow        <= 1'b0;
    end else begin
      if (x_wr) x_wp <= x_wp + LOG2_DEPTH'(1);
      if (x_rd) x_rp <= x_rp + LOG2_DEPTH'(1);
      if (v_wr) v_wp <= v_wp + LOG2_DEPTH'(1);
      if (v_rd) v_rp <= v_rp + LOG2_DEPTH'(1);
      x_cnt           <= x_cnt_nxt;
      v_cnt           <= v_cnt_nxt;
      x_stall         <= (x_cnt_nxt >= CW'(DEPTH - AF_MARGIN));
      val_almost_full <= (v_cnt_nxt >= CW'(DEPTH - AF_MARGIN));
      if (x_drop || v_drop) overflow <= 1'b1;
    end
  end

  // Output register: capture both FIFO heads on a join, otherwise hold data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_push    <= 1'b0;
      out_val     <= '0;
      out_x       <= '0;
      out_row_end <= 1'b0;
      pair_count  <= '0;
    end else begin
      out_push <= join_go;
      if (join_go) begin
        out_x       <= x_mem[x_rp];
        out_val     <= v_mem[v_rp][63:0];
        out_row_end <= v_mem[v_rp][64];
        pair_count  <= pair_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_x_val_joiner.sv
// Testbench for x_val_joiner: queue-based reference model, randomized and
// directed stimulus, all comparisons through one checking task.
module tb_x_val_joiner;

  localparam int DEPTH = 16;
  localparam int AFM   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        push_x = 1'b0;
  logic [63:0] x_val = '0;
  logic        x_stall;
  logic        push_val = 1'b0;
  logic [63:0] val = '0;
  logic        row_end = 1'b0;
  logic        val_almost_full;
  logic        out_push;
  logic [63:0] out_val;
  logic [63:0] out_x;
  logic        out_row_end;
  logic        out_stall = 1'b0;
  logic        overflow;
  logic [31:0] pair_count;

  x_val_joiner #(.DEPTH(DEPTH), .LOG2_DEPTH(4), .AF_MARGIN(AFM)) dut (
    .clk(clk), .rst(rst),
    .push_x(push_x), .x_val(x_val), .x_stall(x_stall),
    .push_val(push_val), .val(val), .row_end(row_end),
    .val_almost_full(val_almost_full),
    .out_push(out_push), .out_val(out_val), .out_x(out_x),
    .out_row_end(out_row_end), .out_stall(out_stall),
    .overflow(overflow), .pair_count(pair_count)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  string       phase   = "init";

  // Reference model state
  logic [63:0] xq[$];
  logic [64:0] vq[$];
  logic        m_push, m_re, m_ovf, m_xaf, m_vaf;
  logic [63:0] m_val, m_x;
  logic [31:0] m_pc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s:%s got=0x%0h expected=0x%0h", phase, tag, got, exp);
    end
  endtask

  task automatic model_reset();
    xq.delete();
    vq.delete();
    m_push = 0; m_re = 0; m_ovf = 0; m_xaf = 0; m_vaf = 0;
    m_val = '0; m_x = '0; m_pc = '0;
  endtask

  // Effect of the next rising edge given current model state and inputs
  task automatic model_step();
    logic [64:0] vh;
    if (xq.size() > 0 && vq.size() > 0 && !out_stall) begin
      vh     = vq.pop_front();
      m_x    = xq.pop_front();
      m_val  = vh[63:0];
      m_re   = vh[64];
      m_push = 1;
      m_pc   = m_pc + 1;
    end else begin
      m_push = 0;
    end
    if (push_x)   begin if (xq.size() < DEPTH) xq.push_back(x_val); else m_ovf = 1; end
    if (push_val) begin if (vq.size() < DEPTH) vq.push_back({row_end, val}); else m_ovf = 1; end
    m_xaf = (xq.size() >= DEPTH - AFM);
    m_vaf = (vq.size() >= DEPTH - AFM);
  endtask

  task automatic compare_all();
    check("out_push", 64'(out_push), 64'(m_push));
    check("out_val", out_val, m_val);
    check("out_x", out_x, m_x);
    check("out_row_end", 64'(out_row_end), 64'(m_re));
    check("x_stall", 64'(x_stall), 64'(m_xaf));
    check("val_af", 64'(val_almost_full), 64'(m_vaf));
    check("overflow", 64'(overflow), 64'(m_ovf));
    check("pair_count", 64'(pair_count), 64'(m_pc));
  endtask

  // One clock: check outputs of the previous edge, drive new inputs, advance model
  task automatic cycle(input logic px, input logic [63:0] xv, input logic pv,
                       input logic [63:0] vv, input logic re, input logic os);
    @(negedge clk);
    compare_all();
    push_x = px; x_val = xv; push_val = pv; val = vv; row_end = re; out_stall = os;
    model_step();
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cycle(0, '0, 0, '0, 0, 0);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    push_x = 0; push_val = 0; out_stall = 0; row_end = 0;
    rst = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    model_reset();
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1;

    // Reset state and asynchronous reset mid-stream
    phase = "reset";
    cycle(1, 64'h11, 1, 64'h22, 1, 0);
    cycle(1, 64'h12, 1, 64'h23, 0, 1);
    cycle(1, 64'h13, 1, 64'h24, 0, 1);
    cycle(1, 64'h14, 1, 64'h25, 0, 1);
    cycle(0, '0, 0, '0, 0, 1);
    @(negedge clk);
    compare_all();
    #2 rst = 0;
    #1;
    check("async_out_push", 64'(out_push), 64'd0);
    check("async_out_val", out_val, 64'd0);
    check("async_out_x", out_x, 64'd0);
    check("async_row_end", 64'(out_row_end), 64'd0);
    check("async_pc", 64'(pair_count), 64'd0);
    check("async_x_stall", 64'(x_stall), 64'd0);
    push_x = 0; push_val = 0; out_stall = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    model_reset();
    idle(4);

    // Basic join: vals first, then x values
    phase = "join";
    reset_dut();
    cycle(0, '0, 1, 64'd5, 0, 0);
    cycle(0, '0, 1, 64'd6, 0, 0);
    cycle(0, '0, 1, 64'd7, 1, 0);
    cycle(1, 64'd10, 0, '0, 0, 0);
    cycle(1, 64'd11, 0, '0, 0, 0);
    cycle(1, 64'd12, 0, '0, 0, 0);
    idle(3);
    check("pc3", 64'(pair_count), 64'd3);
    check("last_row_end", 64'(out_row_end), 64'd1);

    // Downstream stall holds back four buffered pairs
    phase = "stall";
    reset_dut();
    for (int unsigned i = 0; i < 4; i++) cycle(1, 64'(100 + i), 1, 64'(200 + i), i == 3, 1);
    cycle(0, '0, 0, '0, 0, 1);
    idle(6);
    check("pc4", 64'(pair_count), 64'd4);

    // x FIFO fills, 17th push dropped, then 16 vals drain it
    phase = "full";
    reset_dut();
    for (int unsigned i = 0; i < 17; i++) cycle(1, 64'(300 + i), 0, '0, 0, 0);
    for (int unsigned i = 0; i < 16; i++) cycle(0, '0, 1, 64'(400 + i), i[2], 0);
    idle(4);
    check("ovf_set", 64'(overflow), 64'd1);
    check("pc16", 64'(pair_count), 64'd16);

    // Push on a full x FIFO in the same cycle it pops is accepted
    phase = "fullpop";
    reset_dut();
    for (int unsigned i = 0; i < 16; i++) cycle(1, 64'(500 + i), 0, '0, 0, 0);
    cycle(0, '0, 1, 64'd600, 0, 0);
    cycle(1, 64'd516, 0, '0, 0, 0);
    idle(2);
    check("no_ovf", 64'(overflow), 64'd0);
    for (int unsigned i = 0; i < 16; i++) cycle(0, '0, 1, 64'(601 + i), 0, 0);
    idle(3);
    check("pc17", 64'(pair_count), 64'd17);

    // 40 random pairs, random stall, pushes honour the almost-full flags
    phase = "wrap";
    reset_dut();
    begin
      int unsigned nx = 0, nv = 0, guard = 0;
      logic px, pv;
      while ((nx < 40 || nv < 40) && guard < 2000) begin
        px = (nx < 40) && !m_xaf && ($urandom_range(0, 3) != 0);
        pv = (nv < 40) && !m_vaf && ($urandom_range(0, 3) != 0);
        cycle(px, rnd64(), pv, rnd64(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        if (px) nx++;
        if (pv) nv++;
        guard++;
      end
      check("wrap_guard", 64'(guard < 2000), 64'd1);
    end
    idle(DEPTH + 4);
    check("pc40", 64'(pair_count), 64'd40);

    // Unthrottled random traffic, overflow allowed
    phase = "rand";
    reset_dut();
    for (int unsigned i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 1)), rnd64(), 1'($urandom_range(0, 1)), rnd64(),
            1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0);
    idle(DEPTH + 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
